// File: rtl/slc3_input_conditioner_if.sv
// Button/switch bundle between the raw board inputs and the input conditioner.
// master drives the raw inputs; slave is the conditioner itself.
interface slc3_input_conditioner_if #(
    parameter int unsigned SW_WIDTH = 10
);
    logic                run_n_i;
    logic                continue_n_i;
    logic [SW_WIDTH-1:0] sw_i;
    logic                run_pulse_o;
    logic                continue_pulse_o;
    logic                run_level_o;
    logic                continue_level_o;
    logic [SW_WIDTH-1:0] sw_sync_o;

    modport master (
        output run_n_i, continue_n_i, sw_i,
        input  run_pulse_o, continue_pulse_o, run_level_o, continue_level_o, sw_sync_o
    );

    modport slave (
        input  run_n_i, continue_n_i, sw_i,
        output run_pulse_o, continue_pulse_o, run_level_o, continue_level_o, sw_sync_o
    );
endinterface

// File: rtl/slc3_input_conditioner.sv
// Synchronizes and debounces the Run/Continue buttons and synchronizes the slide switches.
// Define BTN_DEBOUNCE_EN to compile in the per-button debounce counters.
//
// state    | meaning
// RELEASED | debounced button level 0
// PRESSED  | debounced button level 1
module slc3_input_conditioner #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned SW_WIDTH  = 10
) (
    input logic                    clk_i,
    input logic                    rst_i,
    slc3_input_conditioner_if.slave io
);
    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} btn_state_e;

    if (DB_CYCLES == 0 || DB_CYCLES > 32'd1048576) begin : g_bad_db_cycles
        $error("DB_CYCLES must lie in 1..2^20");
    end

    logic [1:0]          btn_s1_q;
    logic [1:0]          btn_s2_q;
    logic [SW_WIDTH-1:0] sw_s1_q;
    logic [SW_WIDTH-1:0] sw_s2_q;
    logic [1:0]          level_w;
    logic [1:0]          pulse_w;

    // Buttons reset to the released (high) level so a held button reads as a fresh press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_s1_q <= 2'b11;
            btn_s2_q <= 2'b11;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= {io.continue_n_i, io.run_n_i};
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= io.sw_i;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // Index 0 is Run, index 1 is Continue.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        btn_state_e state_q;
        btn_state_e state_d;
        logic       pulse_q;
        logic       pulse_d;
        logic       pressed;

        assign pressed = ~btn_s2_q[b];

`ifdef BTN_DEBOUNCE_EN
        localparam int unsigned CW = $clog2(DB_CYCLES + 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          rise_q;
        logic          rise_d;

        // Counter only runs while the sample disagrees with the level, so it stays below DB_CYCLES.
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            rise_d  = 1'b0;
            pulse_d = rise_q;
            if ((state_q == PRESSED) != pressed) begin
                if (cnt_q == CW'(DB_CYCLES - 1)) begin
                    state_d = pressed ? PRESSED : RELEASED;
                    rise_d  = pressed;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q  <= '0;
                rise_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                rise_q <= rise_d;
            end
        end
`else
        // Without debounce the pulse registers on the same edge the level follows the sample.
        always_comb begin
            state_d = pressed ? PRESSED : RELEASED;
            pulse_d = (state_q == RELEASED) && pressed;
        end
`endif

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= RELEASED;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                pulse_q <= pulse_d;
            end
        end

        assign level_w[b] = (state_q == PRESSED);
        assign pulse_w[b] = pulse_q;
    end

    assign io.run_pulse_o      = pulse_w[0];
    assign io.continue_pulse_o = pulse_w[1];
    assign io.run_level_o      = level_w[0];
    assign io.continue_level_o = level_w[1];
    assign io.sw_sync_o        = sw_s2_q;
endmodule
